// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 counter-mode issue controller:
// datapath widths, controller state encoding, keystream FIFO entry layout
// and the counter-field increment helper.
package aes_pkg;

   localparam int AES_BLOCK_W  = 128;
   localparam int AES_KEY256_W = 256;

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // One keystream FIFO entry: job-final tag plus the core output block
   typedef struct packed {
      logic                   last;
      logic [AES_BLOCK_W-1:0] data;
   } ks_entry_t;

   // Increment only the low cnt_w bits of a counter block (wrapping inside
   // that field); the bits above the field are passed through untouched.
   function automatic logic [AES_BLOCK_W-1:0] ctr_inc(
      input logic [AES_BLOCK_W-1:0] ctr,
      input int unsigned            cnt_w
   );
      logic [AES_BLOCK_W-1:0] mask;
      if (cnt_w >= AES_BLOCK_W) begin
         mask = {AES_BLOCK_W{1'b1}};
      end else begin
         mask = (128'd1 << cnt_w) - 128'd1;
      end
      return (ctr & ~mask) | ((ctr + 128'd1) & mask);
   endfunction

endpackage

// File: rtl/aes_256_ctr_ctrl_chk.sv
// Runtime checks for the counter-mode controller: the keystream FIFO is
// never written while full (unless a pop frees the slot), and every credit
// is accounted for as either free, in flight through the core, or parked
// in the FIFO.
module aes_256_ctr_ctrl_chk #(
   parameter int FIFO_DEPTH = 32,
   parameter int LATENCY    = 29,
   parameter int CRW        = 6,
   parameter int CW         = 6
) (
   input logic             clk,
   input logic             rst_n,
   input logic             push,
   input logic             pop,
   input logic             full,
   input logic [CRW-1:0]   credit,
   input logic [CW-1:0]    count,
   input logic [LATENCY:0] vld_pipe
);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop));

   a_credit_conservation: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(credit) + int'(count) + $countones(vld_pipe)) == FIFO_DEPTH);

endmodule

// File: rtl/aes_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always
// visible on rd_data while not empty. Push and pop in the same cycle are
// legal at any occupancy; a pop on empty is ignored and a push on full is
// only accepted when a pop frees the slot in the same cycle.
module aes_sync_fifo #(
   parameter  int WIDTH = 129,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             pop_s;
   logic             push_s;

   assign empty   = (count_r == {CW{1'b0}});
   assign full    = (count_r == CW'(DEPTH));
   assign count   = count_r;
   assign rd_data = mem[rd_ptr_r];
   assign pop_s   = pop && !empty;
   assign push_s  = push && (!full || pop_s);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array write port; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/aes_256_ctr_ctrl.sv
// Counter-mode issue controller around a free-running, non-stallable
// aes_256 pipeline. A job (key, initial counter block, block count) is
// accepted in IDLE; in RUN one counter block per cycle is driven into the
// core whenever a FIFO credit is free. A valid/last delay line matched to
// the core depth marks which core outputs belong to the job, and those are
// parked in a FWFT FIFO exposed as the keystream port. Because issue spends
// a credit that only a keystream pop returns, the FIFO can never overflow.
import aes_pkg::*;

module aes_256_ctr_ctrl #(
   parameter int LATENCY    = 29,
   parameter int FIFO_DEPTH = 32,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [AES_KEY256_W-1:0] cfg_key,
   input  logic [AES_BLOCK_W-1:0]  cfg_iv,
   input  logic [CNT_W-1:0]        cfg_nblocks,
   output logic [AES_BLOCK_W-1:0]  core_state,
   output logic [AES_KEY256_W-1:0] core_key,
   input  logic [AES_BLOCK_W-1:0]  core_out,
   output logic                    ks_valid,
   input  logic                    ks_ready,
   output logic [AES_BLOCK_W-1:0]  ks_data,
   output logic                    ks_last,
   output logic                    busy
);

   localparam int CRW = $clog2(FIFO_DEPTH + 1);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]              state_r;
   logic [1:0]              state_next_s;
   logic                    cfg_ready_r;
   logic                    busy_r;
   logic [AES_KEY256_W-1:0] key_r;
   logic [AES_BLOCK_W-1:0]  ctr_r;
   logic [CNT_W-1:0]        remaining_r;
   logic [CRW-1:0]          credit_r;
   logic [AES_BLOCK_W-1:0]  core_state_r;
   logic [AES_KEY256_W-1:0] core_key_r;
   // Bit 0 is the newest issue, bit LATENCY lines up with core_out
   logic [LATENCY:0]        vld_pipe_r;
   logic [LATENCY:0]        last_pipe_r;

   logic                    hs_s;
   logic                    issue_s;
   logic                    last_issue_s;
   logic                    pop_s;
   logic                    fifo_push_s;
   logic                    fifo_empty_s;
   logic                    fifo_full_s;
   logic [FCW-1:0]          fifo_count_s;
   ks_entry_t               fifo_wr_s;
   ks_entry_t               fifo_rd_s;

   assign hs_s         = cfg_valid && cfg_ready_r && (state_r == ST_IDLE);
   assign issue_s      = (state_r == ST_RUN) && (remaining_r != {CNT_W{1'b0}})
                         && (credit_r != {CRW{1'b0}});
   assign last_issue_s = issue_s && (remaining_r == CNT_W'(1));
   assign pop_s        = !fifo_empty_s && ks_ready;
   assign fifo_push_s  = vld_pipe_r[LATENCY];

   // Build the FIFO write entry from the delay-line tag and core output
   always_comb begin
      fifo_wr_s      = '0;
      fifo_wr_s.last = last_pipe_r[LATENCY];
      fifo_wr_s.data = core_out;
   end

   // Next-state selection for IDLE / RUN / DRAIN
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hs_s && (cfg_nblocks != {CNT_W{1'b0}})) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_issue_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if ((vld_pipe_r == {(LATENCY+1){1'b0}}) && fifo_empty_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register plus registered cfg_ready/busy decoded from next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cfg_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cfg_ready_r <= (state_next_s == ST_IDLE);
         busy_r      <= (state_next_s != ST_IDLE);
      end
   end

   // Job context: latched on the handshake, advanced on every issue
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_r       <= {AES_KEY256_W{1'b0}};
         ctr_r       <= {AES_BLOCK_W{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
      end else if (hs_s) begin
         key_r       <= cfg_key;
         ctr_r       <= cfg_iv;
         remaining_r <= cfg_nblocks;
      end else if (issue_s) begin
         ctr_r       <= ctr_inc(ctr_r, CNT_W);
         remaining_r <= remaining_r - CNT_W'(1);
      end
   end

   // Registered core inputs; they hold their value on stall cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_state_r <= {AES_BLOCK_W{1'b0}};
         core_key_r   <= {AES_KEY256_W{1'b0}};
      end else if (issue_s) begin
         core_state_r <= ctr_r;
         core_key_r   <= key_r;
      end
   end

   // Valid/last delay line tracking which core outputs belong to the job
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe_r  <= {(LATENCY+1){1'b0}};
         last_pipe_r <= {(LATENCY+1){1'b0}};
      end else begin
         vld_pipe_r  <= {vld_pipe_r[LATENCY-1:0], issue_s};
         last_pipe_r <= {last_pipe_r[LATENCY-1:0], last_issue_s};
      end
   end

   // Credit counter: spent on issue, returned on keystream pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_r <= CRW'(FIFO_DEPTH);
      end else begin
         case ({issue_s, pop_s})
            2'b10:   credit_r <= credit_r - CRW'(1);
            2'b01:   credit_r <= credit_r + CRW'(1);
            default: credit_r <= credit_r;
         endcase
      end
   end

   aes_sync_fifo #(
      .WIDTH ($bits(ks_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push_s),
      .wr_data (fifo_wr_s),
      .pop     (pop_s),
      .rd_data (fifo_rd_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s),
      .count   (fifo_count_s)
   );

   aes_256_ctr_ctrl_chk #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LATENCY    (LATENCY),
      .CRW        (CRW),
      .CW         (FCW)
   ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push_s),
      .pop      (pop_s),
      .full     (fifo_full_s),
      .credit   (credit_r),
      .count    (fifo_count_s),
      .vld_pipe (vld_pipe_r)
   );

   assign cfg_ready  = cfg_ready_r;
   assign busy       = busy_r;
   assign core_state = core_state_r;
   assign core_key   = core_key_r;
   assign ks_valid   = !fifo_empty_s;
   assign ks_data    = fifo_rd_s.data;
   assign ks_last    = fifo_rd_s.last && !fifo_empty_s;

endmodule

// File: tb/tb_aes_256_ctr_ctrl.sv
// Bench for aes_256_ctr_ctrl. A behavioural AES-256 core model (plain
// FIPS-197 byte arithmetic, LATENCY-deep delay) feeds core_out; the
// reference keystream for each job is computed directly as
// E(K, iv + i) and compared beat by beat on the keystream port.
module tb_aes_256_ctr_ctrl;

   localparam int LATENCY    = 29;
   localparam int FIFO_DEPTH = 32;
   localparam int CNT_W      = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [255:0] cfg_key = '0;
   logic [127:0] cfg_iv = '0;
   logic [31:0]  cfg_nblocks = '0;
   logic [127:0] core_state;
   logic [255:0] core_key;
   logic [127:0] core_out;
   logic         ks_valid;
   logic         ks_ready = 1'b0;
   logic [127:0] ks_data;
   logic         ks_last;
   logic         busy;

   aes_256_ctr_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_nblocks(cfg_nblocks),
      .core_state(core_state), .core_key(core_key), .core_out(core_out),
      .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
      .ks_last(ks_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- AES-256 reference ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [127:0] aes256(input logic [255:0] key, input logic [127:0] pt);
      logic [31:0]  w [60];
      logic [31:0]  t;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [7:0]   s [16];
      logic [7:0]   n [16];
      logic [127:0] rk, res;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      rk = {w[0], w[1], w[2], w[3]};
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
      for (int r = 1; r <= 14; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) n[4*c+q] = s[4*((c+q)%4)+q];
         for (int c = 0; c < 4; c++) begin
            a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
            if (r != 14) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Behavioural core: output LATENCY cycles after the input is presented
   logic [127:0] core_pipe [LATENCY];
   always @(posedge clk) begin
      core_pipe[0] <= aes256(core_key, core_state);
      for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_out = core_pipe[LATENCY-1];

   // ---------------- checking infrastructure ----------------
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int beats = 0;
   int prev_beat = -1;
   int bubbles = 0;
   bit rnd_ready = 1'b0;
   bit ready_val = 1'b1;
   bit cap_en = 1'b0;
   logic [128:0] exp_q [$];
   logic [127:0] cs_q [$];
   logic [7:0]   inv_v, aff_v;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive ks_ready for the coming edge and score a pop if any
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      ks_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : ready_val;
      if (rst_n) begin
         chk("credit_sum", 256'(int'(dut.credit_r) + int'(dut.u_fifo.count)
             + $countones(dut.vld_pipe_r)), 256'(FIFO_DEPTH));
      end
      if (cap_en && (cs_q.size() == 0 || cs_q[$] != core_state)) cs_q.push_back(core_state);
      if (ks_valid && ks_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {ks_last, ks_data}, 256'h0);
            failures++;
            $error("FAIL stray_beat observed=1 expected=0");
         end else begin
            chk($sformatf("beat%0d", beats), {ks_last, ks_data}, exp_q.pop_front());
         end
         if (prev_beat >= 0 && cyc != prev_beat + 1) bubbles++;
         prev_beat = cyc;
         beats++;
      end
   endtask

   task automatic start_job(input logic [255:0] k, input logic [127:0] iv, input logic [31:0] n);
      int g;
      g = 0;
      cfg_key = k; cfg_iv = iv; cfg_nblocks = n; cfg_valid = 1'b1;
      while (!cfg_ready && g < 200) begin tick(); g++; end
      chk("cfg_ready_wait", {255'h0, (g < 200)}, 256'h1);
      for (int i = 0; i < int'(n); i++)
         exp_q.push_back({(i == int'(n) - 1), aes256(k, {iv[127:32], iv[31:0] + 32'(i)})});
      beats = 0; prev_beat = -1; bubbles = 0;
      tick();
      hs_cyc = cyc;
      cfg_valid = 1'b0;
      cfg_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      cfg_iv = {$urandom(), $urandom(), $urandom(), $urandom()};
      cfg_nblocks = $urandom_range(1, 9);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int g;
      g = 0;
      while ((busy || exp_q.size() != 0) && g < limit) begin tick(); g++; end
      chk(tag, {255'h0, (g < limit)}, 256'h1);
   endtask

   function automatic logic [255:0] rkey();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic [255:0] k;
      logic [127:0] iv;
      int g, lat, n_before;
      bit saw_valid, saw_busy;

      for (int x = 0; x < 256; x++) begin
         inv_v = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv_v = 8'(y);
         aff_v = inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3)
                 ^ rotl8(inv_v, 4) ^ 8'h63;
         sbox[x] = aff_v;
      end

      // Reset state
      repeat (3) tick();
      chk("rst_cfg_ready", {255'h0, cfg_ready}, 256'h0);
      chk("rst_ks_valid", {255'h0, ks_valid}, 256'h0);
      chk("rst_ks_last", {255'h0, ks_last}, 256'h0);
      chk("rst_busy", {255'h0, busy}, 256'h0);
      chk("rst_core_state", {128'h0, core_state}, 256'h0);
      chk("rst_core_key", core_key, 256'h0);
      rst_n = 1'b1;
      tick();
      chk("idle_cfg_ready", {255'h0, cfg_ready}, 256'h1);

      // Single block, FIPS-197 C.3 vector
      k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      iv = 128'h00112233445566778899aabbccddeeff;
      start_job(k, iv, 32'd1);
      g = 0;
      while (!ks_valid && g < 100) begin tick(); g++; end
      lat = cyc - hs_cyc;
      chk("single_latency", 256'(lat), 256'(LATENCY + 2));
      chk("single_fips_c3", {128'h0, ks_data}, {128'h0, 128'h8ea2b7ca516745bfeafc49904b496089});
      chk("single_last", {255'h0, ks_last}, 256'h1);
      wait_done("single_done", 20);
      chk("single_beats", 256'(beats), 256'd1);
      chk("single_busy_low", {255'h0, busy}, 256'h0);

      // Streaming, ready held high
      start_job(rkey(), {$urandom(), $urandom(), $urandom(), 32'h1000_0000}, 32'd100);
      wait_done("stream_done", 400);
      chk("stream_beats", 256'(beats), 256'd100);
      chk("stream_bubbles", 256'(bubbles), 256'd0);

      // Backpressure, ready ~30% duty
      rnd_ready = 1'b1;
      start_job(rkey(), {$urandom(), $urandom(), $urandom(), $urandom()}, 32'd200);
      wait_done("bp_done", 3000);
      chk("bp_beats", 256'(beats), 256'd200);
      rnd_ready = 1'b0;

      // Counter wrap in the low 32-bit field
      iv = {$urandom(), $urandom(), $urandom(), 32'hFFFF_FFFE};
      cs_q.delete();
      cap_en = 1'b1;
      start_job(rkey(), iv, 32'd4);
      wait_done("wrap_done", 200);
      cap_en = 1'b0;
      chk("wrap_beats", 256'(beats), 256'd4);
      while (cs_q.size() != 0 && cs_q[0][127:32] != iv[127:32]) void'(cs_q.pop_front());
      chk("wrap_nctr", 256'(cs_q.size()), 256'd4);
      for (int i = 0; i < 4 && i < cs_q.size(); i++)
         chk($sformatf("wrap_ctr%0d", i), {128'h0, cs_q[i]},
             {128'h0, iv[127:32], iv[31:0] + 32'(i)});

      // Zero-length job
      n_before = checks;
      start_job(rkey(), {$urandom(), $urandom(), $urandom(), $urandom()}, 32'd0);
      chk("zero_cfg_ready", {255'h0, cfg_ready}, 256'h1);
      chk("zero_busy", {255'h0, busy}, 256'h0);
      saw_valid = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ks_valid) saw_valid = 1'b1;
         if (busy) saw_busy = 1'b1;
      end
      chk("zero_no_valid", {255'h0, saw_valid}, 256'h0);
      chk("zero_no_busy", {255'h0, saw_busy}, 256'h0);
      chk("zero_progress", 256'(checks > n_before), 256'h1);

      // Reset during a job, then a short fresh job
      start_job(rkey(), {$urandom(), $urandom(), $urandom(), 32'h0000_0100}, 32'd50);
      g = 0;
      while (beats < 10 && g < 300) begin tick(); g++; end
      chk("mid_reached10", {255'h0, (g < 300)}, 256'h1);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      chk("mid_rst_cfg_ready", {255'h0, cfg_ready}, 256'h0);
      chk("mid_rst_ks_valid", {255'h0, ks_valid}, 256'h0);
      chk("mid_rst_busy", {255'h0, busy}, 256'h0);
      rst_n = 1'b1;
      tick();
      start_job(rkey(), {$urandom(), $urandom(), $urandom(), $urandom()}, 32'd2);
      wait_done("post_rst_done", 200);
      repeat (60) tick();
      chk("post_rst_beats", 256'(beats), 256'd2);
      chk("post_rst_q_empty", 256'(exp_q.size()), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
